// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory behind a valid/ready request/response handshake.
// Each accepted request produces one response a fixed LATENCY cycles later.
module mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWr,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqData,
    input  logic [7:0]  ReqMask,
    output logic        RspValid,
    input  logic        RspReady,
    output logic [31:0] RspData,
    output logic        RspErr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   r_rsp_data;
    logic          r_rsp_err;
    logic          w_accept, w_oor, w_unused;
    logic [AW-1:0] w_idx;

    assign w_idx    = ReqAddr[AW+1:2];
    assign w_oor    = ReqAddr[31:AW+2] != '0;
    assign w_accept = ReqValid && r_state == IDLE && !Rst;
    assign w_unused = ^{ReqMask[7:4], ReqAddr[1:0]};

    assign ReqReady = r_state == IDLE;
    assign RspValid = r_state == RESP;
    assign RspData  = r_rsp_data;
    assign RspErr   = r_rsp_err;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        unique case (r_state)
            IDLE: if (ReqValid) begin
                w_next     = LATENCY == 1 ? RESP : WAIT;
                w_cnt_next = CW'(LATENCY - 1);
            end
            WAIT: begin
                w_cnt_next = r_cnt - CW'(1);
                w_next     = r_cnt == CW'(1) ? RESP : WAIT;
            end
            RESP: w_next = RspReady ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_rsp_data <= (w_oor || ReqWr) ? '0 : r_mem[w_idx];
                r_rsp_err  <= w_oor;
            end
        end
    end

    // Array has no reset: contents survive Rst and a committed write is never undone.
    always_ff @(posedge Clk) begin
        if (w_accept && ReqWr && !w_oor)
            for (int b = 0; b < 4; b++)
                if (ReqMask[b]) r_mem[w_idx][8*b +: 8] <= ReqData[8*b +: 8];
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed and random checks of two mem_responder builds
// (LATENCY=2 and LATENCY=1) against an associative-array memory model.
module tb_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rq_valid [2];
    logic        rq_ready [2];
    logic        rq_wr    [2];
    logic [31:0] rq_addr  [2];
    logic [31:0] rq_data  [2];
    logic [7:0]  rq_mask  [2];
    logic        rs_valid [2];
    logic        rs_ready [2];
    logic [31:0] rs_data  [2];
    logic        rs_err   [2];

    mem_responder #(.DEPTH(256), .LATENCY(2)) u0 (
        .Clk(clk), .Rst(rst),
        .ReqValid(rq_valid[0]), .ReqReady(rq_ready[0]), .ReqWr(rq_wr[0]),
        .ReqAddr(rq_addr[0]), .ReqData(rq_data[0]), .ReqMask(rq_mask[0]),
        .RspValid(rs_valid[0]), .RspReady(rs_ready[0]),
        .RspData(rs_data[0]), .RspErr(rs_err[0])
    );

    mem_responder #(.DEPTH(256), .LATENCY(1)) u1 (
        .Clk(clk), .Rst(rst),
        .ReqValid(rq_valid[1]), .ReqReady(rq_ready[1]), .ReqWr(rq_wr[1]),
        .ReqAddr(rq_addr[1]), .ReqData(rq_data[1]), .ReqMask(rq_mask[1]),
        .RspValid(rs_valid[1]), .RspReady(rs_ready[1]),
        .RspData(rs_data[1]), .RspErr(rs_err[1])
    );

    int          checks = 0;
    int          errors = 0;
    bit [31:0]   model [int];
    int          known [2][$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction on build d; caller is at a negedge, returns at a negedge.
    task automatic txn(input int d, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [7:0] mask, input int hold);
        int          n, key, lat;
        logic        oor, known_word;
        logic [31:0] exp_data, m, got;
        lat        = d == 0 ? 2 : 1;
        oor        = addr[31:10] != 22'd0;
        key        = d * 256 + int'(addr[9:2]);
        known_word = model.exists(key);
        exp_data   = (oor || wr || !known_word) ? 32'd0 : model[key];
        m = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        chk("req_ready_idle", rq_ready[d], 1'b1);
        rq_valid[d] = 1'b1; rq_wr[d] = wr; rq_addr[d] = addr;
        rq_data[d] = data; rq_mask[d] = mask;
        @(posedge clk);
        @(negedge clk);
        rq_valid[d] = 1'b0; rq_wr[d] = ~wr; rq_addr[d] = $urandom;
        rq_data[d] = $urandom; rq_mask[d] = 8'($urandom);
        if (wr && !oor)
            model[key] = ((known_word ? model[key] : 32'd0) & ~m) | (data & m);
        n = 1;
        while (rs_valid[d] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, lat);
        chk("rsp_err", rs_err[d], oor);
        if (oor || wr || known_word) chk("rsp_data", rs_data[d], exp_data);
        chk("req_ready_busy", rq_ready[d], 1'b0);
        got = rs_data[d];
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", rs_valid[d], 1'b1);
            chk("hold_data", rs_data[d], got);
            chk("hold_req_ready", rq_ready[d], 1'b0);
        end
        rs_ready[d] = 1'b1;
        @(negedge clk);
        rs_ready[d] = 1'b0;
        chk("rsp_done", rs_valid[d], 1'b0);
        chk("req_ready_after", rq_ready[d], 1'b1);
    endtask

    initial begin
        logic [31:0] a;
        int          d;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rq_valid[i] = 0; rq_wr[i] = 0; rq_addr[i] = 0;
            rq_data[i] = 0; rq_mask[i] = 0; rs_ready[i] = 0;
        end
        #1;
        chk("rst_req_ready", rq_ready[0], 1'b1);
        chk("rst_rsp_valid", rs_valid[0], 1'b0);
        chk("rst_rsp_data", rs_data[0], 32'd0);
        chk("rst_rsp_err", rs_err[0], 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Full write, read-back, partial write, no-op write.
        txn(0, 1, 32'h10, 32'hDEADBEEF, 8'h0F, 0);
        txn(0, 0, 32'h10, 32'h0, 8'h00, 0);
        txn(0, 1, 32'h10, 32'h00001234, 8'hF3, 0);
        txn(0, 0, 32'h11, 32'h0, 8'hFF, 0);
        chk("partial_model", model[16'h4], 32'hDEAD1234);
        txn(0, 1, 32'h10, 32'hFFFFFFFF, 8'hF0, 0);
        txn(0, 0, 32'h12, 32'h0, 8'h0, 0);
        // Out-of-range read and write leave the aliased word untouched.
        txn(0, 0, 32'h400, 32'h0, 8'h0, 0);
        txn(0, 1, 32'h410, 32'h55555555, 8'hFF, 0);
        txn(0, 0, 32'h10, 32'h0, 8'h0, 0);
        // Back-pressure in RESP.
        txn(0, 0, 32'h10, 32'h0, 8'h0, 5);

        // Reset mid-WAIT after a write: response dropped, write kept.
        rq_valid[0] = 1; rq_wr[0] = 1; rq_addr[0] = 32'h20;
        rq_data[0] = 32'hCAFEF00D; rq_mask[0] = 8'h0F;
        @(posedge clk);
        @(negedge clk);
        rq_valid[0] = 0;
        model[8] = 32'hCAFEF00D;
        chk("wait_valid_low", rs_valid[0], 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_async_valid", rs_valid[0], 1'b0);
        chk("rst_async_ready", rq_ready[0], 1'b1);
        chk("rst_async_data", rs_data[0], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("no_stale_rsp", rs_valid[0], 1'b0);
        end
        txn(0, 0, 32'h20, 32'h0, 8'h0, 0);
        txn(0, 0, 32'h10, 32'h0, 8'h0, 1);

        // LATENCY=1 build: top word via byte address 0x3FC and 0x3FD.
        txn(1, 1, 32'h3FC, 32'h0BADC0DE, 8'h0F, 0);
        txn(1, 0, 32'h3FD, 32'h0, 8'h0, 2);
        txn(1, 0, 32'h800, 32'h0, 8'h0, 0);

        // Random traffic: seed words with full writes, then mixed operations.
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 12; j++) begin
                a = {22'd0, 8'($urandom), 2'($urandom)};
                txn(i, 1, a, $urandom, 8'hFF, 0);
                known[i].push_back(int'(a[9:2]));
            end
        for (int j = 0; j < 80; j++) begin
            d = int'($urandom_range(0, 1));
            a = {22'd0, 8'(known[d][$urandom_range(0, known[d].size() - 1)]), 2'($urandom)};
            if ($urandom_range(0, 7) == 0) a[31:10] = 22'($urandom_range(1, 32'h3FFFFF));
            txn(d, 1'($urandom), a, $urandom, 8'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
